// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 32-point radix-2 DIT FFT.
// Twiddles are W32^m = cos - j*sin in Q2.14; only the first half circle is needed.
package fft_pkg;

    localparam int FFT_SIZE  = 32;
    localparam int IN_WIDTH  = 12;
    localparam int OUT_WIDTH = 16;
    localparam int INT_WIDTH = 18;
    localparam int TW_WIDTH  = 16;
    localparam int LOG2_SIZE = 5;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } fft_state_e;

    localparam logic signed [TW_WIDTH-1:0] TW_COS [16] = '{
        16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
        16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196,
        16'sd0,     -16'sd3196,  -16'sd6270,  -16'sd9102,
       -16'sd11585, -16'sd13623, -16'sd15137, -16'sd16069
    };

    localparam logic signed [TW_WIDTH-1:0] TW_SIN [16] = '{
        16'sd0,      16'sd3196,   16'sd6270,   16'sd9102,
        16'sd11585,  16'sd13623,  16'sd15137,  16'sd16069,
        16'sd16384,  16'sd16069,  16'sd15137,  16'sd13623,
        16'sd11585,  16'sd9102,   16'sd6270,   16'sd3196
    };

    function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [INT_WIDTH-1:0] v);
        if (v > 18'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -18'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[OUT_WIDTH-1:0];
        end
    endfunction

    function automatic logic [LOG2_SIZE-1:0] bitrev5(input logic [LOG2_SIZE-1:0] a);
        return {a[0], a[1], a[2], a[3], a[4]};
    endfunction

    // Top address of butterfly b in stage s: insert a zero at bit position s.
    function automatic logic [LOG2_SIZE-1:0] bf_top(input logic [3:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return {b[3:0], 1'b0};
            3'd1:    return {b[3:1], 1'b0, b[0]};
            3'd2:    return {b[3:2], 1'b0, b[1:0]};
            3'd3:    return {b[3], 1'b0, b[2:0]};
            3'd4:    return {1'b0, b[3:0]};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [LOG2_SIZE-1:0] bf_bot(input logic [3:0] b, input logic [2:0] s);
        return bf_top(b, s) | (5'd1 << s);
    endfunction

    // Twiddle exponent: position within the group scaled up to the 32-point circle.
    function automatic logic [3:0] bf_tw(input logic [3:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return 4'd0;
            3'd1:    return {b[0], 3'd0};
            3'd2:    return {b[1:0], 2'd0};
            3'd3:    return {b[2:0], 1'b0};
            3'd4:    return b[3:0];
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: x = a + b*w, y = a - b*w.
// The product is kept full width, rounded half-up, then shifted down by 14.
module fft_butterfly
    import fft_pkg::*;
(
    input  logic signed [INT_WIDTH-1:0] i_a_re,
    input  logic signed [INT_WIDTH-1:0] i_a_im,
    input  logic signed [INT_WIDTH-1:0] i_b_re,
    input  logic signed [INT_WIDTH-1:0] i_b_im,
    input  logic signed [TW_WIDTH-1:0]  i_w_re,
    input  logic signed [TW_WIDTH-1:0]  i_w_im,
    output logic signed [INT_WIDTH-1:0] o_x_re,
    output logic signed [INT_WIDTH-1:0] o_x_im,
    output logic signed [INT_WIDTH-1:0] o_y_re,
    output logic signed [INT_WIDTH-1:0] o_y_im
);

    localparam int PW = INT_WIDTH + TW_WIDTH + 1;
    localparam logic signed [PW-1:0] RND = PW'(32'sd8192);

    logic signed [PW-1:0]        w_pr;
    logic signed [PW-1:0]        w_pi;
    logic signed [INT_WIDTH-1:0] w_t_re;
    logic signed [INT_WIDTH-1:0] w_t_im;

    assign w_pr   = PW'(i_b_re) * PW'(i_w_re) - PW'(i_b_im) * PW'(i_w_im) + RND;
    assign w_pi   = PW'(i_b_re) * PW'(i_w_im) + PW'(i_b_im) * PW'(i_w_re) + RND;
    assign w_t_re = INT_WIDTH'(w_pr >>> 5'd14);
    assign w_t_im = INT_WIDTH'(w_pi >>> 5'd14);

    assign o_x_re = i_a_re + w_t_re;
    assign o_x_im = i_a_im + w_t_im;
    assign o_y_re = i_a_re - w_t_re;
    assign o_y_im = i_a_im - w_t_im;

endmodule

// File: rtl/fft_32pt.sv
// 32-point frame FFT: bit-reversed load, 5 in-place DIT stages with two butterflies
// per cycle (40 cycles), then 32 results streamed in natural order with saturation.
module fft_32pt
    import fft_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic signed [IN_WIDTH-1:0]  din_r,
    input  logic signed [IN_WIDTH-1:0]  din_i,
    output logic                        out_valid,
    output logic signed [OUT_WIDTH-1:0] dout_r,
    output logic signed [OUT_WIDTH-1:0] dout_i
);

    localparam logic [5:0] LAST_LOAD = 6'd31;
    localparam logic [5:0] LAST_COMP = 6'd39;
    localparam logic [5:0] LAST_OUT  = 6'd31;

    fft_state_e                  r_state;
    logic [5:0]                  r_cnt;
    logic                        r_out_valid;
    logic signed [OUT_WIDTH-1:0] r_dout_r;
    logic signed [OUT_WIDTH-1:0] r_dout_i;
    logic signed [INT_WIDTH-1:0] r_mem_re [FFT_SIZE];
    logic signed [INT_WIDTH-1:0] r_mem_im [FFT_SIZE];

    logic [LOG2_SIZE-1:0]        w_top  [2];
    logic [LOG2_SIZE-1:0]        w_bot  [2];
    logic signed [INT_WIDTH-1:0] w_x_re [2];
    logic signed [INT_WIDTH-1:0] w_x_im [2];
    logic signed [INT_WIDTH-1:0] w_y_re [2];
    logic signed [INT_WIDTH-1:0] w_y_im [2];

    // During COMPUTE, r_cnt[5:3] is the stage and r_cnt[2:0] selects a butterfly pair.
    for (genvar g = 0; g < 2; g++) begin : g_bf
        logic [3:0]                 w_bidx;
        logic [3:0]                 w_tw;
        logic signed [TW_WIDTH-1:0] w_w_re;
        logic signed [TW_WIDTH-1:0] w_w_im;

        assign w_bidx   = {r_cnt[2:0], 1'(g)};
        assign w_top[g] = bf_top(w_bidx, r_cnt[5:3]);
        assign w_bot[g] = bf_bot(w_bidx, r_cnt[5:3]);
        assign w_tw     = bf_tw(w_bidx, r_cnt[5:3]);
        assign w_w_re   = TW_COS[w_tw];
        assign w_w_im   = -TW_SIN[w_tw];

        fft_butterfly u_bf (
            .i_a_re (r_mem_re[w_top[g]]),
            .i_a_im (r_mem_im[w_top[g]]),
            .i_b_re (r_mem_re[w_bot[g]]),
            .i_b_im (r_mem_im[w_bot[g]]),
            .i_w_re (w_w_re),
            .i_w_im (w_w_im),
            .o_x_re (w_x_re[g]),
            .o_x_im (w_x_im[g]),
            .o_y_re (w_y_re[g]),
            .o_y_im (w_y_im[g])
        );
    end

    // Frame FSM, working memory and registered output stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= LOAD;
            r_cnt       <= 6'd0;
            r_out_valid <= 1'b0;
            r_dout_r    <= 16'sd0;
            r_dout_i    <= 16'sd0;
            for (int i = 0; i < FFT_SIZE; i++) begin
                r_mem_re[i] <= 18'sd0;
                r_mem_im[i] <= 18'sd0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    r_out_valid <= 1'b0;
                    r_dout_r    <= 16'sd0;
                    r_dout_i    <= 16'sd0;
                    // The cycle right after OUTPUT still shows the last result; ignore input there.
                    if (in_valid && !r_out_valid) begin
                        r_mem_re[bitrev5(r_cnt[4:0])] <= INT_WIDTH'(din_r);
                        r_mem_im[bitrev5(r_cnt[4:0])] <= INT_WIDTH'(din_i);
                        if (r_cnt == LAST_LOAD) begin
                            r_state <= COMPUTE;
                            r_cnt   <= 6'd0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                    end
                end
                COMPUTE: begin
                    for (int g = 0; g < 2; g++) begin
                        r_mem_re[w_top[g]] <= w_x_re[g];
                        r_mem_im[w_top[g]] <= w_x_im[g];
                        r_mem_re[w_bot[g]] <= w_y_re[g];
                        r_mem_im[w_bot[g]] <= w_y_im[g];
                    end
                    if (r_cnt == LAST_COMP) begin
                        r_state <= OUTPUT;
                        r_cnt   <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                OUTPUT: begin
                    r_out_valid <= 1'b1;
                    r_dout_r    <= sat_out(r_mem_re[r_cnt[4:0]]);
                    r_dout_i    <= sat_out(r_mem_im[r_cnt[4:0]]);
                    if (r_cnt == LAST_OUT) begin
                        r_state <= LOAD;
                        r_cnt   <= 6'd0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state     <= LOAD;
                    r_cnt       <= 6'd0;
                    r_out_valid <= 1'b0;
                    r_dout_r    <= 16'sd0;
                    r_dout_i    <= 16'sd0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign dout_r    = r_dout_r;
    assign dout_i    = r_dout_i;

endmodule

// File: tb/tb_fft_32pt.sv
// Scoreboard bench for fft_32pt: a double-precision DFT model queues expected bins
// as each frame is driven; a monitor pops and compares them as results stream out.
module tb_fft_32pt;

    localparam real PI = 3.14159265358979323846;

    typedef struct {
        int re;
        int im;
        int tol;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [11:0] din_r;
    logic signed [11:0] din_i;
    logic               out_valid;
    logic signed [15:0] dout_r;
    logic signed [15:0] dout_i;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   fr_re [32];
    int   fr_im [32];
    int   sine_tab [32] = '{0, 99, 191, 271, 332, 370, 384, 370, 332, 271, 192, 99,
                            0, -100, -192, -272, -333, -371, -384, -371, -333, -272, -193, -100,
                            -1, 99, 191, 271, 332, 370, 384, 370};
    int   cyc = 0;
    int   last_cyc;
    bit   lat_arm;
    int   run_len;
    bit   prev_ov;

    fft_32pt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din_r     (din_r),
        .din_i     (din_i),
        .out_valid (out_valid),
        .dout_r    (dout_r),
        .dout_i    (dout_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp, input int tol);
        n_vec++;
        if ((obs - exp) > tol || (exp - obs) > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    function automatic int sat16(input real v);
        int r;
        r = int'(v);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic push_expected(input int tol);
        exp_t e;
        real  acc_re;
        real  acc_im;
        real  ang;
        for (int k = 0; k < 32; k++) begin
            acc_re = 0.0;
            acc_im = 0.0;
            for (int n = 0; n < 32; n++) begin
                ang    = 2.0 * PI * real'(n * k) / 32.0;
                acc_re = acc_re + real'(fr_re[n]) * $cos(ang) + real'(fr_im[n]) * $sin(ang);
                acc_im = acc_im + real'(fr_im[n]) * $cos(ang) - real'(fr_re[n]) * $sin(ang);
            end
            e.re  = sat16(acc_re);
            e.im  = sat16(acc_im);
            e.tol = tol;
            sb_q.push_back(e);
        end
    endtask

    task automatic make_frame(input int kind);
        for (int n = 0; n < 32; n++) begin
            fr_re[n] = 0;
            fr_im[n] = 0;
            case (kind)
                0: fr_re[n] = (n == 0) ? 100 : 0;
                1: fr_re[n] = 100;
                2: fr_re[n] = int'(1000.0 * $cos(2.0 * PI * real'(n) / 32.0));
                3: fr_re[n] = sine_tab[n];
                4: begin fr_re[n] = 2047;  fr_im[n] = 2047;  end
                5: begin fr_re[n] = -2048; fr_im[n] = -2048; end
                default: fr_re[n] = 0;
            endcase
        end
    endtask

    // Caller is positioned just after a falling edge; returns likewise.
    task automatic send_frame(input int tol, input bit gaps);
        push_expected(tol);
        for (int n = 0; n < 32; n++) begin
            if (gaps && (n % 3 == 1)) begin
                repeat ($urandom_range(1, 3)) begin
                    in_valid = 1'b0;
                    din_r    = 12'($urandom);
                    din_i    = 12'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            din_r    = 12'(fr_re[n]);
            din_i    = 12'(fr_im[n]);
            @(posedge clk);
            if (n == 31) begin
                #1;
                last_cyc = cyc;
                lat_arm  = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit noise);
        int i = 0;
        while ((sb_q.size() != 0 || out_valid) && i < 300) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                din_r    = 12'($urandom);
                din_i    = 12'($urandom);
            end
            @(negedge clk);
            i++;
        end
        in_valid = 1'b0;
        chk("drain", sb_q.size(), 0, 0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run_len = 0;
                prev_ov = 1'b0;
            end else begin
                if (out_valid) begin
                    if (!prev_ov && lat_arm) begin
                        chk("lat_le60", int'((cyc - last_cyc) <= 60), 1, 0);
                        lat_arm = 1'b0;
                    end
                    if (sb_q.size() == 0) begin
                        chk("unexp_out", int'(out_valid), 0, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("X%0d_re", run_len), dout_r, e.re, e.tol);
                        chk($sformatf("X%0d_im", run_len), dout_i, e.im, e.tol);
                    end
                    run_len++;
                end else begin
                    if (prev_ov) chk("ov_run", run_len, 32, 0);
                    run_len = 0;
                    chk("idle_re", dout_r, 0, 0);
                    chk("idle_im", dout_i, 0, 0);
                end
                prev_ov = out_valid;
            end
        end
    endtask

    initial begin
        int i;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        din_r    = 12'sd0;
        din_i    = 12'sd0;
        lat_arm  = 1'b0;
        run_len  = 0;
        prev_ov  = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", int'(out_valid), 0, 0);
        chk("rst_dr", dout_r, 0, 0);
        chk("rst_di", dout_i, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        make_frame(0); send_frame(1, 1'b0); wait_done(1'b0);
        make_frame(1); send_frame(1, 1'b0); wait_done(1'b0);
        make_frame(2); send_frame(8, 1'b0); wait_done(1'b0);
        make_frame(3); send_frame(8, 1'b0); wait_done(1'b0);
        make_frame(4); send_frame(1, 1'b0); wait_done(1'b0);
        make_frame(5); send_frame(1, 1'b0); wait_done(1'b0);
        make_frame(2); send_frame(8, 1'b1); wait_done(1'b1);
        make_frame(0); send_frame(1, 1'b0); wait_done(1'b0);

        make_frame(3); send_frame(8, 1'b0);
        i = 0;
        while (!out_valid && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("ov_rise", int'(out_valid), 1, 0);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ov", int'(out_valid), 0, 0);
        chk("arst_dr", dout_r, 0, 0);
        chk("arst_di", dout_i, 0, 0);
        sb_q.delete();
        lat_arm = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        make_frame(2); send_frame(8, 1'b0); wait_done(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
